// File: rtl/branch_predictor_pkg.sv
`default_nettype none
// ============================================================================
//  lx32_branch_pkg
//  Shared types and helpers for the LX32 branch target buffer.
//  Revision: 1.0
// ============================================================================

package lx32_branch_pkg;

  // 2-bit direction counter: the MSB alone is the taken prediction.
  typedef enum logic [1:0] {
    BP_SNT = 2'd0,
    BP_WNT = 2'd1,
    BP_WT  = 2'd2,
    BP_ST  = 2'd3
  } bp_ctr_e;

  localparam bp_ctr_e BP_CTR_RESET = BP_WNT;
  localparam bp_ctr_e BP_CTR_ALLOC = BP_WT;

  function automatic bp_ctr_e bp_ctr_next(input bp_ctr_e ctr, input logic taken);
    bp_ctr_e nxt;
    nxt = ctr;
    case (ctr)
      BP_SNT:  nxt = taken ? BP_WNT : BP_SNT;
      BP_WNT:  nxt = taken ? BP_WT  : BP_SNT;
      BP_WT:   nxt = taken ? BP_ST  : BP_WNT;
      BP_ST:   nxt = taken ? BP_ST  : BP_WT;
      default: nxt = BP_CTR_RESET;
    endcase
    return nxt;
  endfunction

  function automatic logic bp_ctr_predicts_taken(input bp_ctr_e ctr);
    return (ctr == BP_WT) || (ctr == BP_ST);
  endfunction

endpackage

`default_nettype wire

// File: rtl/branch_predictor_if.sv
`default_nettype none
// ============================================================================
//  branch_predictor_if
//  Fetch lookup and execute update channels of the branch target buffer.
//  Revision: 1.0
// ============================================================================

interface branch_predictor_if #(
  parameter int WIDTH = 32
);

  logic [WIDTH-1:0] lookup_pc;
  logic             pred_taken;
  logic [WIDTH-1:0] pred_target;

  logic             upd_valid;
  logic [WIDTH-1:0] upd_pc;
  logic             upd_taken;
  logic [WIDTH-1:0] upd_target;

  logic             flush;

  // Pipeline side: drives lookups, resolved branches and invalidation.
  modport master (
    output lookup_pc,
    output upd_valid,
    output upd_pc,
    output upd_taken,
    output upd_target,
    output flush,
    input  pred_taken,
    input  pred_target
  );

  // Predictor side.
  modport slave (
    input  lookup_pc,
    input  upd_valid,
    input  upd_pc,
    input  upd_taken,
    input  upd_target,
    input  flush,
    output pred_taken,
    output pred_target
  );

endinterface

`default_nettype wire

// File: rtl/branch_predictor_sat_counter.sv
`default_nettype none
// ============================================================================
//  bp_sat_counter
//  Next-state logic of one 2-bit saturating direction counter.
//  Revision: 1.0
// ============================================================================

module bp_sat_counter
  import lx32_branch_pkg::*;
(
  input  bp_ctr_e ctr,
  input  logic    taken,
  output bp_ctr_e ctr_next,
  output logic    predict_taken
);

  assign ctr_next      = bp_ctr_next(ctr, taken);
  assign predict_taken = bp_ctr_predicts_taken(ctr);

endmodule

`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
//  branch_predictor
//  Direct-mapped BTB with 2-bit counters: combinational lookup, edge update.
//  Revision: 1.0
// ============================================================================

module branch_predictor
  import lx32_branch_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int ENTRIES = 64
) (
  input  logic              clk,
  input  logic              rst,
  branch_predictor_if.slave bp
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = WIDTH - IDX_W - 2;

  if ((ENTRIES < 2) || ((ENTRIES & (ENTRIES - 1)) != 0)) begin : g_bad_entries
    $error("branch_predictor: ENTRIES must be a power of two and at least 2");
  end

  // --------------------------------------------------------------------------
  // Table storage
  // --------------------------------------------------------------------------
  logic             r_valid  [ENTRIES];
  logic [TAG_W-1:0] r_tag    [ENTRIES];
  logic [WIDTH-1:0] r_target [ENTRIES];
  bp_ctr_e          r_ctr    [ENTRIES];

  // --------------------------------------------------------------------------
  // Lookup path
  // --------------------------------------------------------------------------
  logic [IDX_W-1:0] w_lk_idx;
  logic [TAG_W-1:0] w_lk_tag;
  logic             w_lk_hit;
  logic             w_lk_ctr_taken;

  assign w_lk_idx = bp.lookup_pc[IDX_W+1:2];
  assign w_lk_tag = bp.lookup_pc[WIDTH-1:IDX_W+2];
  assign w_lk_hit = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);

  assign w_lk_ctr_taken = bp_ctr_predicts_taken(r_ctr[w_lk_idx]);

  // No bypass: a same-cycle update to this index is seen from the next cycle.
  assign bp.pred_taken  = w_lk_hit && w_lk_ctr_taken;
  assign bp.pred_target = bp.pred_taken ? r_target[w_lk_idx]
                                        : bp.lookup_pc + WIDTH'(4);

  // --------------------------------------------------------------------------
  // Update path
  // --------------------------------------------------------------------------
  logic [IDX_W-1:0] w_up_idx;
  logic [TAG_W-1:0] w_up_tag;
  logic             w_up_hit;
  logic             w_up_en;
  bp_ctr_e          w_up_ctr_next;
  logic             w_up_ctr_taken;

  assign w_up_idx = bp.upd_pc[IDX_W+1:2];
  assign w_up_tag = bp.upd_pc[WIDTH-1:IDX_W+2];
  assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

  // Flush outranks a same-cycle update; reset outranks both.
  assign w_up_en = bp.upd_valid && !bp.flush && !rst;

  bp_sat_counter u_sat_counter (
    .ctr           (r_ctr[w_up_idx]),
    .taken         (bp.upd_taken),
    .ctr_next      (w_up_ctr_next),
    .predict_taken (w_up_ctr_taken)
  );

  logic w_unused;
  assign w_unused = w_up_ctr_taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_ctr[i]   <= BP_CTR_RESET;
      end
    end else if (bp.flush) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
      end
    end else if (bp.upd_valid) begin
      if (w_up_hit) begin
        r_ctr[w_up_idx] <= w_up_ctr_next;
      end else if (bp.upd_taken) begin
        r_valid[w_up_idx] <= 1'b1;
        r_ctr[w_up_idx]   <= BP_CTR_ALLOC;
      end
    end
  end

  // Tag/target carry no reset: they are meaningless until valid is set.
  always_ff @(posedge clk) begin
    if (w_up_en && bp.upd_taken) begin
      r_tag[w_up_idx]    <= w_up_tag;
      r_target[w_up_idx] <= bp.upd_target;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
//  tb_branch_predictor
//  Directed and randomized checks of branch_predictor against a table model.
//  Revision: 1.0
// ============================================================================

module tb_branch_predictor;

  localparam int W     = 32;
  localparam int N     = 64;
  localparam int IDX_W = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  branch_predictor_if #(.WIDTH(W)) bus ();

  branch_predictor #(.WIDTH(W), .ENTRIES(N)) dut (
    .clk (clk),
    .rst (rst),
    .bp  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference table
  bit           m_valid  [N];
  logic [W-1:0] m_tag    [N];
  logic [W-1:0] m_target [N];
  int           m_ctr    [N];

  logic         obs_taken;
  logic [W-1:0] obs_target;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int idx_of(input logic [W-1:0] pc);
    return int'((pc >> 2) % N);
  endfunction

  function automatic logic [W-1:0] tag_of(input logic [W-1:0] pc);
    return pc >> (IDX_W + 2);
  endfunction

  task automatic model_lookup(input logic [W-1:0] pc, output logic t, output logic [W-1:0] tgt);
    int i;
    i = idx_of(pc);
    if (m_valid[i] && m_tag[i] == tag_of(pc) && m_ctr[i] >= 2) begin
      t   = 1'b1;
      tgt = m_target[i];
    end else begin
      t   = 1'b0;
      tgt = pc + 32'd4;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
    end
  endtask

  task automatic model_apply(input bit uv, input logic [W-1:0] upc, input bit ut,
                             input logic [W-1:0] utgt, input bit fl, input bit r);
    int i;
    i = idx_of(upc);
    if (r) begin
      model_reset();
    end else if (fl) begin
      for (int k = 0; k < N; k++) m_valid[k] = 1'b0;
    end else if (uv) begin
      if (m_valid[i] && m_tag[i] == tag_of(upc)) begin
        if (ut) begin
          m_ctr[i]    = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
          m_target[i] = utgt;
        end else begin
          m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
        end
      end else if (ut) begin
        m_valid[i]  = 1'b1;
        m_tag[i]    = tag_of(upc);
        m_target[i] = utgt;
        m_ctr[i]    = 2;
      end
    end
  endtask

  // One cycle: drive after the falling edge, sample mid-cycle, model the edge.
  task automatic step(input logic [W-1:0] lpc, input bit uv, input logic [W-1:0] upc,
                      input bit ut, input logic [W-1:0] utgt, input bit fl, input bit r,
                      input string tag);
    logic         et;
    logic [W-1:0] etg;
    @(negedge clk);
    bus.lookup_pc  = lpc;
    bus.upd_valid  = uv;
    bus.upd_pc     = upc;
    bus.upd_taken  = ut;
    bus.upd_target = utgt;
    bus.flush      = fl;
    rst            = r;
    #1;
    model_lookup(lpc, et, etg);
    obs_taken  = bus.pred_taken;
    obs_target = bus.pred_target;
    check({tag, ".taken"}, W'(obs_taken), W'(et));
    check({tag, ".target"}, obs_target, etg);
    @(posedge clk);
    model_apply(uv, upc, ut, utgt, fl, r);
  endtask

  task automatic look(input logic [W-1:0] pc, input string tag);
    step(pc, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, tag);
  endtask

  task automatic look_upd(input logic [W-1:0] lpc, input logic [W-1:0] upc, input bit ut,
                          input logic [W-1:0] utgt, input string tag);
    step(lpc, 1'b1, upc, ut, utgt, 1'b0, 1'b0, tag);
  endtask

  task automatic expect_pred(input string tag, input bit t, input logic [W-1:0] tgt);
    check({tag, ".const_taken"}, W'(obs_taken), W'(t));
    check({tag, ".const_target"}, obs_target, tgt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.lookup_pc  = '0;
    bus.upd_valid  = 1'b0;
    bus.upd_pc     = '0;
    bus.upd_taken  = 1'b0;
    bus.upd_target = '0;
    bus.flush      = 1'b0;
    rst            = 1'b1;
    repeat (2) @(posedge clk);
    model_reset();

    // Reset state and +4 wraparound
    step(32'h0000_1000, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1, "in_rst");
    expect_pred("in_rst", 1'b0, 32'h0000_1004);
    look(32'h0000_1000, "post_rst");
    expect_pred("post_rst", 1'b0, 32'h0000_1004);
    look(32'hFFFF_FFFC, "wrap");
    expect_pred("wrap", 1'b0, 32'h0000_0000);

    // Allocation, no same-cycle bypass, counter training both ways
    look_upd(32'h100, 32'h100, 1'b1, 32'h80, "same_cycle");
    expect_pred("same_cycle", 1'b0, 32'h104);
    look_upd(32'h100, 32'h100, 1'b1, 32'h80, "alloc_wt");
    expect_pred("alloc_wt", 1'b1, 32'h80);
    look_upd(32'h100, 32'h100, 1'b1, 32'h80, "st");
    look_upd(32'h100, 32'h100, 1'b0, 32'h0, "st_sat");
    expect_pred("st_sat", 1'b1, 32'h80);
    look_upd(32'h100, 32'h100, 1'b0, 32'h0, "wt");
    expect_pred("wt", 1'b1, 32'h80);
    look_upd(32'h100, 32'h100, 1'b0, 32'h0, "wnt");
    expect_pred("wnt", 1'b0, 32'h104);
    look_upd(32'h100, 32'h100, 1'b0, 32'h0, "snt");
    look_upd(32'h100, 32'h100, 1'b1, 32'h80, "snt_sat");
    look(32'h100, "snt_plus_taken");
    expect_pred("snt_plus_taken", 1'b0, 32'h104);

    // Aliasing eviction
    look_upd(32'h200, 32'h100, 1'b1, 32'h80, "alias_miss");
    expect_pred("alias_miss", 1'b0, 32'h204);
    look_upd(32'h100, 32'h200, 1'b1, 32'h40, "pre_evict");
    expect_pred("pre_evict", 1'b1, 32'h80);
    look(32'h200, "evictor");
    expect_pred("evictor", 1'b1, 32'h40);
    look(32'h100, "evicted");
    expect_pred("evicted", 1'b0, 32'h104);

    // Miss + not taken leaves the table alone
    look_upd(32'h500, 32'h500, 1'b0, 32'h10, "miss_nt");
    look(32'h500, "miss_nt_after");
    expect_pred("miss_nt_after", 1'b0, 32'h504);

    // Flush beats a same-cycle update
    look_upd(32'h100, 32'h100, 1'b1, 32'h80, "realloc");
    step(32'h100, 1'b1, 32'h300, 1'b1, 32'h90, 1'b1, 1'b0, "flush_cyc");
    expect_pred("flush_cyc", 1'b1, 32'h80);
    look(32'h100, "flushed_100");
    expect_pred("flushed_100", 1'b0, 32'h104);
    look(32'h300, "flushed_300");
    expect_pred("flushed_300", 1'b0, 32'h304);

    // Hit-taken retargets; hit-not-taken keeps the target
    look_upd(32'h104, 32'h104, 1'b1, 32'h10, "tgt_alloc");
    look_upd(32'h104, 32'h104, 1'b1, 32'h20, "tgt_retarget");
    look_upd(32'h104, 32'h104, 1'b0, 32'h99, "tgt_nt");
    look(32'h104, "tgt_keep");
    expect_pred("tgt_keep", 1'b1, 32'h20);

    // Reset mid-training; first edge out of reset accepts an update
    step(32'h104, 1'b1, 32'h104, 1'b1, 32'h77, 1'b0, 1'b1, "rst_mid");
    expect_pred("rst_mid", 1'b1, 32'h20);
    look_upd(32'h104, 32'h104, 1'b1, 32'h30, "rst_after");
    expect_pred("rst_after", 1'b0, 32'h108);
    look(32'h106, "low_bits_ignored");
    expect_pred("low_bits_ignored", 1'b1, 32'h30);

    // Randomized traffic over a small alias-heavy address pool
    for (int n = 0; n < 800; n++) begin
      logic [W-1:0] lpc, upc, utgt;
      bit           uv, ut, fl, r;
      lpc  = (W'($urandom_range(0, 3)) << 8) | (W'($urandom_range(0, 7)) << 2) | W'($urandom_range(0, 3));
      upc  = (W'($urandom_range(0, 3)) << 8) | (W'($urandom_range(0, 7)) << 2) | W'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) lpc = $urandom;
      if ($urandom_range(0, 3) == 0) lpc = upc;
      utgt = $urandom;
      uv   = ($urandom_range(0, 99) < 70);
      ut   = ($urandom_range(0, 99) < 60);
      fl   = ($urandom_range(0, 99) < 2);
      r    = ($urandom_range(0, 199) == 0);
      step(lpc, uv, upc, ut, utgt, fl, r, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
